// File: rtl/frame_defs.sv
// Shared definitions for the nibble frame receiver: state encoding, default sync
// nibble and error-counter width.
package frame_defs;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam logic [3:0]  SYNC_DEFAULT = 4'b1011;
    localparam int unsigned ERR_CNT_W    = 8;

endpackage

// File: rtl/bit_slot_counter.sv
// Two-bit bit-slot counter; flags the last bit of each nibble slot while counting.
module bit_slot_counter (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic boundary
);

    logic [1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            bit_cnt_d = 2'd0;
        end else if (enable) begin
            bit_cnt_d = bit_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bit_cnt_q <= 2'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign boundary = enable && !load && (bit_cnt_q == 2'd3);

endmodule

// File: rtl/nibble_frame_receiver.sv
// Sync-hunting nibble framer with miss flywheel fed by a 4-bit shift register.
// Define ERR_COUNT_EN to add the saturating err_cnt sync-miss counter.
module nibble_frame_receiver
    import frame_defs::*;
#(
    parameter logic [3:0]  SYNC          = SYNC_DEFAULT,
    parameter int unsigned FRAME_NIBBLES = 2,
    parameter int unsigned MAX_MISS      = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 Q0,
    input  logic                 Q1,
    input  logic                 Q2,
    input  logic                 Q3,
    output logic [3:0]           data,
    output logic                 data_valid,
    output logic                 locked,
`ifdef ERR_COUNT_EN
    output logic                 sync_miss,
    output logic [ERR_CNT_W-1:0] err_cnt
`else
    output logic                 sync_miss
`endif
);

    localparam logic [3:0] LAST_NIB   = 4'(FRAME_NIBBLES - 1);
    localparam logic [2:0] MISS_LIMIT = 3'(MAX_MISS);

    state_e     state_q, state_d;
    logic [3:0] nib_cnt_q, nib_cnt_d;
    logic [2:0] miss_cnt_q, miss_cnt_d;
    logic [3:0] data_q, data_d;
    logic       data_valid_q, data_valid_d;
    logic       locked_q, locked_d;
    logic       sync_miss_q, sync_miss_d;

    logic [3:0] nibble;
    logic       in_hunt;
    logic       boundary;

    assign nibble  = {Q3, Q2, Q1, Q0};
    assign in_hunt = (state_q == HUNT);

    // Held at zero while hunting so the first slot starts right after the sync edge.
    bit_slot_counter u_bit_slot_counter (
        .clock    (clock),
        .clear    (clear),
        .load     (in_hunt),
        .enable   (!in_hunt),
        .boundary (boundary)
    );

    always_comb begin
        state_d      = state_q;
        nib_cnt_d    = nib_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        sync_miss_d  = 1'b0;

        case (state_q)
            HUNT: begin
                if (nibble == SYNC) begin
                    state_d    = DATA;
                    nib_cnt_d  = 4'd0;
                    miss_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (boundary) begin
                    data_d       = nibble;
                    data_valid_d = 1'b1;
                    if (nib_cnt_q == LAST_NIB) begin
                        state_d   = CHECK;
                        nib_cnt_d = 4'd0;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 4'd1;
                    end
                end
            end
            CHECK: begin
                if (boundary) begin
                    if (nibble == SYNC) begin
                        miss_cnt_d = 3'd0;
                        state_d    = DATA;
                    end else begin
                        sync_miss_d = 1'b1;
                        miss_cnt_d  = miss_cnt_q + 3'd1;
                        if (miss_cnt_d == MISS_LIMIT) begin
                            state_d    = HUNT;
                            miss_cnt_d = 3'd0;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        locked_d = (state_d != HUNT);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= HUNT;
            nib_cnt_q    <= 4'd0;
            miss_cnt_q   <= 3'd0;
            data_q       <= 4'd0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_miss_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            nib_cnt_q    <= nib_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
            sync_miss_q  <= sync_miss_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign locked     = locked_q;
    assign sync_miss  = sync_miss_q;

`ifdef ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sync_miss_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_nibble_frame_receiver.sv
// Self-checking bench: drives an upstream serial shift register and compares the
// receiver against a frame-offset reference model.
module tb_nibble_frame_receiver;

    localparam logic [3:0] SYNC = 4'b1011;
    localparam int         FN   = 2;
    localparam int         MM   = 2;

    logic       clock = 1'b0;
    logic       clear;
    logic [3:0] sr;
    logic [3:0] data;
    logic       data_valid;
    logic       locked;
    logic       sync_miss;
`ifdef ERR_COUNT_EN
    logic [7:0] err_cnt;
`endif

    nibble_frame_receiver dut (
        .clock      (clock),
        .clear      (clear),
        .Q0         (sr[0]),
        .Q1         (sr[1]),
        .Q2         (sr[2]),
        .Q3         (sr[3]),
        .data       (data),
        .data_valid (data_valid),
        .locked     (locked),
`ifdef ERR_COUNT_EN
        .sync_miss  (sync_miss),
        .err_cnt    (err_cnt)
`else
        .sync_miss  (sync_miss)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: lock anchored at the sync edge; slots located by edge offset.
    bit         m_locked;
    int         m_anchor;
    int         m_t;
    int         m_miss;
    int         m_err;
    logic [3:0] m_data;
    logic       m_dv;
    logic       m_sm;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_anchor = 0;
        m_miss   = 0;
        m_err    = 0;
        m_data   = 4'd0;
        m_dv     = 1'b0;
        m_sm     = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] n);
        int off;
        int slot;
        m_t++;
        m_dv = 1'b0;
        m_sm = 1'b0;
        if (!m_locked) begin
            if (n == SYNC) begin
                m_locked = 1'b1;
                m_anchor = m_t;
                m_miss   = 0;
            end
        end else begin
            off = m_t - m_anchor;
            if (off % 4 == 0) begin
                slot = (off / 4) % (FN + 1);
                if (slot != 0) begin
                    m_data = n;
                    m_dv   = 1'b1;
                end else if (n == SYNC) begin
                    m_miss = 0;
                end else begin
                    m_sm = 1'b1;
                    m_miss++;
                    if (m_err < 255) m_err++;
                    if (m_miss == MM) begin
                        m_locked = 1'b0;
                        m_miss   = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"},       8'(data),       8'(m_data));
        check({tag, ".data_valid"}, 8'(data_valid), 8'(m_dv));
        check({tag, ".locked"},     8'(locked),     8'(m_locked));
        check({tag, ".sync_miss"},  8'(sync_miss),  8'(m_sm));
`ifdef ERR_COUNT_EN
        check({tag, ".err_cnt"},    err_cnt,        8'(m_err));
`endif
    endtask

    task automatic step(input logic b);
        @(negedge clock);
        sr = {sr[2:0], b};
        @(posedge clock);
        model_edge(sr);
        #1;
        check_outputs("edge");
    endtask

    task automatic send_nib(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) step(v[i]);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        #1 clear = 1'b1;
        #1;
        model_reset();
        check_outputs("clear");
        @(posedge clock);
        #1 clear = 1'b0;
    endtask

    initial begin
        int r;
        sr    = 4'd0;
        clear = 1'b1;
        m_t   = 0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        check_outputs("reset");
        clear = 1'b0;

        for (int i = 0; i < 8; i++) step(1'b0);
        check("idle_locked", 8'(locked), 8'd0);

        send_nib(SYNC);
        check("lock_after_sync", 8'(locked), 8'd1);
        send_nib(4'b0110);
        check("nib0_data", 8'(data), 8'h06);
        check("nib0_valid", 8'(data_valid), 8'd1);
        send_nib(4'b1100);
        check("nib1_data", 8'(data), 8'h0c);
        check("nib1_valid", 8'(data_valid), 8'd1);

        send_nib(SYNC);
        check("good_check_miss", 8'(sync_miss), 8'd0);
        check("good_check_lock", 8'(locked), 8'd1);
        send_nib(4'hA);
        check("after_check_data", 8'(data), 8'h0a);
        send_nib(4'h5);

        send_nib(4'h0);
        check("miss1_pulse", 8'(sync_miss), 8'd1);
        check("miss1_lock", 8'(locked), 8'd1);
        send_nib(4'h3);
        send_nib(4'h9);
        send_nib(SYNC);
        check("recover_miss", 8'(sync_miss), 8'd0);
        send_nib(4'h1);
        send_nib(4'h2);
        send_nib(4'h0);
        check("miss_a_pulse", 8'(sync_miss), 8'd1);
        send_nib(4'h4);
        send_nib(4'h7);
        send_nib(4'h0);
        check("miss_b_pulse", 8'(sync_miss), 8'd1);
        check("miss_b_drop", 8'(locked), 8'd0);

        send_nib(SYNC);
        check("relock", 8'(locked), 8'd1);
        step(1'b1);
        step(1'b0);
        pulse_clear();
        check("clear_lock", 8'(locked), 8'd0);
        check("clear_data", 8'(data), 8'd0);
        for (int i = 0; i < 6; i++) step(1'b0);

        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 19));
            if (r < 14) begin
                send_nib((r < 11) ? SYNC : 4'($urandom));
                for (int k = 0; k < FN; k++) send_nib(4'($urandom));
            end else if (r < 19) begin
                for (int k = 0; k < r - 13; k++) step(1'($urandom));
            end else begin
                pulse_clear();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
